// File: rtl/world_hour_setter.sv
// rtl/world_hour_setter.sv - edit home hour through a world city's time zone and load it back
module world_hour_setter (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] HOUR,
  input  logic [2:0] W_COUNT,
  input  logic       SET_EN,
  input  logic       UP,
  input  logic       DOWN,
  input  logic       COMMIT,
  input  logic       CANCEL,
  input  logic       LOAD_ACK,
  output logic       EDITING,
  output logic [6:0] HOUR_W_EDIT,
  output logic       LOAD_REQ,
  output logic [6:0] HOUR_LOAD,
  output logic       DAY_INC,
  output logic       DAY_DEC
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EDIT    = 2'd1,
    CONVERT = 2'd2,
    REQ     = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nx;

  logic [2:0] city;
  logic [6:0] edit_hour;
  logic [6:0] home_hour;
  logic [6:0] fwd_hour;
  logic [6:0] inv_hour;
  logic       inv_inc;
  logic       inv_dec;
  logic [6:0] load_hour;
  logic       day_inc_q;
  logic       day_dec_q;

  // Out-of-range home hours are treated as midnight before converting.
  assign home_hour = (HOUR > 7'd23) ? 7'd0 : HOUR;

  // Forward conversion home -> world; each branch keeps the result inside 0..23.
  always_comb begin
    fwd_hour = home_hour;
    case (W_COUNT)
      3'd0:    fwd_hour = (home_hour >= 7'd22) ? home_hour - 7'd22 : home_hour + 7'd2;
      3'd1:    fwd_hour = (home_hour == 7'd0)  ? 7'd23             : home_hour - 7'd1;
      3'd2:    fwd_hour = (home_hour >= 7'd14) ? home_hour - 7'd14 : home_hour + 7'd10;
      default: fwd_hour = (home_hour >= 7'd9)  ? home_hour - 7'd9  : home_hour + 7'd15;
    endcase
  end

  // Inverse conversion world -> home from the latched city, flagging the date rollover.
  always_comb begin
    inv_hour = edit_hour;
    inv_inc  = 1'b0;
    inv_dec  = 1'b0;
    case (city)
      3'd0: begin
        if (edit_hour < 7'd2) begin
          inv_hour = edit_hour + 7'd22;
          inv_dec  = 1'b1;
        end else begin
          inv_hour = edit_hour - 7'd2;
        end
      end
      3'd1: begin
        if (edit_hour >= 7'd23) begin
          inv_hour = edit_hour - 7'd23;
          inv_inc  = 1'b1;
        end else begin
          inv_hour = edit_hour + 7'd1;
        end
      end
      3'd2: begin
        if (edit_hour >= 7'd10) begin
          inv_hour = edit_hour - 7'd10;
          inv_inc  = 1'b1;
        end else begin
          inv_hour = edit_hour + 7'd14;
        end
      end
      default: begin
        if (edit_hour >= 7'd15) begin
          inv_hour = edit_hour - 7'd15;
          inv_inc  = 1'b1;
        end else begin
          inv_hour = edit_hour + 7'd9;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and status outputs; CANCEL outranks COMMIT in EDIT, REQ waits only for the ack.
  always_comb begin
    state_nx = state;
    EDITING  = 1'b1;
    LOAD_REQ = 1'b0;
    case (state)
      IDLE: begin
        EDITING = 1'b0;
        if (SET_EN) state_nx = EDIT;
      end
      EDIT: begin
        if (CANCEL)      state_nx = IDLE;
        else if (COMMIT) state_nx = CONVERT;
      end
      CONVERT: begin
        state_nx = REQ;
      end
      REQ: begin
        LOAD_REQ = 1'b1;
        if (LOAD_ACK) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // City latch and edit register; opposing UP/DOWN cancel each other out.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      city      <= 3'd0;
      edit_hour <= 7'd0;
    end else if (state == IDLE && SET_EN) begin
      city      <= W_COUNT;
      edit_hour <= fwd_hour;
    end else if (state == EDIT && !CANCEL && !COMMIT) begin
      if (UP && !DOWN) begin
        edit_hour <= (edit_hour >= 7'd23) ? 7'd0 : edit_hour + 7'd1;
      end else if (DOWN && !UP) begin
        edit_hour <= (edit_hour == 7'd0 || edit_hour > 7'd23) ? 7'd23 : edit_hour - 7'd1;
      end
    end
  end

  // Load value and day flags change only in CONVERT, so they stay put through REQ and after.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      load_hour <= 7'd0;
      day_inc_q <= 1'b0;
      day_dec_q <= 1'b0;
    end else if (state == CONVERT) begin
      load_hour <= inv_hour;
      day_inc_q <= inv_inc;
      day_dec_q <= inv_dec;
    end
  end

  assign HOUR_W_EDIT = edit_hour;
  assign HOUR_LOAD   = load_hour;
  assign DAY_INC     = day_inc_q;
  assign DAY_DEC     = day_dec_q;

endmodule

// File: tb/tb_world_hour_setter.sv
// tb/tb_world_hour_setter.sv - scoreboard bench for world_hour_setter
module tb_world_hour_setter;

  logic       CLK;
  logic       RST;
  logic [6:0] HOUR;
  logic [2:0] W_COUNT;
  logic       SET_EN;
  logic       UP;
  logic       DOWN;
  logic       COMMIT;
  logic       CANCEL;
  logic       LOAD_ACK;
  logic       EDITING;
  logic [6:0] HOUR_W_EDIT;
  logic       LOAD_REQ;
  logic [6:0] HOUR_LOAD;
  logic       DAY_INC;
  logic       DAY_DEC;

  world_hour_setter dut (
    .CLK(CLK), .RST(RST), .HOUR(HOUR), .W_COUNT(W_COUNT),
    .SET_EN(SET_EN), .UP(UP), .DOWN(DOWN), .COMMIT(COMMIT), .CANCEL(CANCEL),
    .LOAD_ACK(LOAD_ACK), .EDITING(EDITING), .HOUR_W_EDIT(HOUR_W_EDIT),
    .LOAD_REQ(LOAD_REQ), .HOUR_LOAD(HOUR_LOAD), .DAY_INC(DAY_INC), .DAY_DEC(DAY_DEC)
  );

  typedef struct {
    int load;
    int inc;
    int dec;
    int rc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // reference model state
  int m_city = 0;
  int m_edit = 0;
  int m_load = 0;
  int m_inc  = 0;
  int m_dec  = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc = cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic int md(input int x);
    return ((x % 24) + 24) % 24;
  endfunction

  // world hour = home hour + offset
  function automatic int off(input int w);
    if (w == 0) return 2;
    if (w == 1) return -1;
    if (w == 2) return -14;
    return -9;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: pops the scoreboard when a request appears, then checks stability while it is held
  logic prev_req = 1'b0;
  exp_t held;
  always @(negedge CLK) begin
    if (RST) begin
      prev_req = 1'b0;
    end else begin
      if (LOAD_REQ && !prev_req) begin
        if (q.size() == 0) begin
          chk("unexpected_load_req", 1, 0);
        end else begin
          held = q.pop_front();
          chk("req_latency", cyc, held.rc);
          chk("hour_load", int'(HOUR_LOAD), held.load);
          chk("day_inc", int'(DAY_INC), held.inc);
          chk("day_dec", int'(DAY_DEC), held.dec);
          chk("editing_in_req", int'(EDITING), 1);
        end
      end else if (LOAD_REQ && prev_req) begin
        chk("hold_hour_load", int'(HOUR_LOAD), held.load);
        chk("hold_day_inc", int'(DAY_INC), held.inc);
        chk("hold_day_dec", int'(DAY_DEC), held.dec);
      end
      prev_req = LOAD_REQ;
    end
  end

  task automatic clear_inputs();
    SET_EN = 0; UP = 0; DOWN = 0; COMMIT = 0; CANCEL = 0; LOAD_ACK = 0;
  endtask

  // called at a negedge; drives for one clock and returns at the following negedge
  task automatic pulse(input logic s, input logic u, input logic d,
                       input logic c, input logic n, input logic a);
    SET_EN = s; UP = u; DOWN = d; COMMIT = c; CANCEL = n; LOAD_ACK = a;
    @(negedge CLK);
    clear_inputs();
  endtask

  task automatic enter(input int w, input int h);
    W_COUNT = 3'(w);
    HOUR = 7'(h);
    m_city = w;
    m_edit = md(((h > 23) ? 0 : h) + off(w));
    pulse(1, 0, 0, 0, 0, 0);
    chk("enter_editing", int'(EDITING), 1);
    chk("enter_edit", int'(HOUR_W_EDIT), m_edit);
    chk("enter_no_req", int'(LOAD_REQ), 0);
  endtask

  task automatic edit_step(input logic u, input logic d, input bit noise);
    if (noise) W_COUNT = 3'($urandom_range(0, 7));
    if (u && !d) m_edit = md(m_edit + 1);
    else if (d && !u) m_edit = md(m_edit - 1);
    pulse(0, u, d, 0, 0, noise ? 1'($urandom_range(0, 1)) : 1'b0);
    chk("edit_value", int'(HOUR_W_EDIT), m_edit);
    chk("edit_editing", int'(EDITING), 1);
  endtask

  task automatic do_cancel(input logic with_commit);
    pulse(0, 0, 0, with_commit, 1, 0);
    chk("cancel_editing", int'(EDITING), 0);
    chk("cancel_no_req", int'(LOAD_REQ), 0);
    chk("cancel_hour_load", int'(HOUR_LOAD), m_load);
    chk("cancel_day_inc", int'(DAY_INC), m_inc);
    chk("cancel_day_dec", int'(DAY_DEC), m_dec);
    chk("cancel_edit_hold", int'(HOUR_W_EDIT), m_edit);
    repeat (2) @(negedge CLK);
  endtask

  // returns 1 if the request showed up in time; leaves the bench at the negedge where it is seen
  task automatic issue_commit(output bit ok);
    exp_t e;
    int raw;
    raw = m_edit - off(m_city);
    e.load = md(raw);
    e.inc = (raw >= 24) ? 1 : 0;
    e.dec = (raw < 0) ? 1 : 0;
    e.rc = cyc + 2;
    q.push_back(e);
    m_load = e.load; m_inc = e.inc; m_dec = e.dec;
    pulse(0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 8 && !LOAD_REQ; k++) @(negedge CLK);
    ok = LOAD_REQ;
    if (!ok) chk("req_timeout", int'(LOAD_REQ), 1);
  endtask

  task automatic do_commit(input int ack_delay, input bit noise);
    bit ok;
    issue_commit(ok);
    if (ok) begin
      for (int i = 0; i < ack_delay; i++) begin
        if (noise) begin
          UP = 1'($urandom_range(0, 1));
          DOWN = 1'($urandom_range(0, 1));
          CANCEL = 1'($urandom_range(0, 1));
          SET_EN = 1'($urandom_range(0, 1));
          COMMIT = 1'($urandom_range(0, 1));
        end
        @(negedge CLK);
        clear_inputs();
        chk("req_held", int'(LOAD_REQ), 1);
      end
      pulse(0, 0, 0, 0, 0, 1);
      chk("ack_req_low", int'(LOAD_REQ), 0);
      chk("ack_editing_low", int'(EDITING), 0);
      chk("ack_edit_hold", int'(HOUR_W_EDIT), m_edit);
    end
  endtask

  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      pulse(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("idle_editing", int'(EDITING), 0);
      chk("idle_edit_hold", int'(HOUR_W_EDIT), m_edit);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_editing"}, int'(EDITING), 0);
    chk({tag, "_edit"}, int'(HOUR_W_EDIT), 0);
    chk({tag, "_load_req"}, int'(LOAD_REQ), 0);
    chk({tag, "_hour_load"}, int'(HOUR_LOAD), 0);
    chk({tag, "_day_inc"}, int'(DAY_INC), 0);
    chk({tag, "_day_dec"}, int'(DAY_DEC), 0);
  endtask

  initial begin
    bit ok;
    int w, h, n, r;
    RST = 1; HOUR = 0; W_COUNT = 0;
    clear_inputs();
    repeat (2) @(negedge CLK);
    check_all_zero("reset");
    RST = 0;
    @(negedge CLK);

    // Tokyo-like city: 5 -> 15, edit to 18, back to 8 next day, slow ack
    enter(2, 5);
    repeat (3) edit_step(1, 0, 0);
    do_commit(4, 0);

    // +2 city: wrap down through midnight
    enter(0, 23);
    edit_step(0, 1, 0);
    edit_step(0, 1, 0);
    do_commit(0, 0);
    enter(0, 23);
    do_commit(1, 0);

    // -1 city: 0 -> 23 -> 0 -> home 1; UP+DOWN together is a no-op
    enter(1, 0);
    edit_step(1, 0, 0);
    edit_step(1, 1, 0);
    do_commit(2, 0);

    // latched city survives a W_COUNT change
    enter(5, 3);
    W_COUNT = 3'd0;
    edit_step(0, 0, 0);
    do_commit(0, 0);

    // cancel beats commit; out-of-range hour treated as 0
    enter(0, 30);
    do_cancel(1);
    idle_noise(3);

    // reset in the middle of a request
    enter(3, 12);
    edit_step(1, 0, 0);
    issue_commit(ok);
    #1;
    RST = 1;
    #1;
    m_edit = 0; m_load = 0; m_inc = 0; m_dec = 0;
    check_all_zero("async_reset");
    @(negedge CLK);
    RST = 0;
    @(negedge CLK);
    chk("post_reset_no_req", int'(LOAD_REQ), 0);

    // randomized sessions
    for (int it = 0; it < 40; it++) begin
      w = $urandom_range(0, 7);
      h = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 23);
      enter(w, h);
      n = $urandom_range(0, 8);
      for (int k = 0; k < n; k++) begin
        edit_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
      end
      r = $urandom_range(0, 3);
      if (r == 0) do_cancel(1'($urandom_range(0, 1)));
      else do_commit($urandom_range(0, 4), 1);
      idle_noise($urandom_range(0, 2));
    end

    repeat (3) @(negedge CLK);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/world_hour_setter.md
# world_hour_setter

Lets the user set the home clock by editing the hour in the selected world city's time zone, the reverse of the home-to-world hour transfer. On entry it converts the current home hour to the city hour and accepts up/down edits. On commit it converts the edited city hour back to a home hour and presents it to the home clock counter over a request/acknowledge load handshake. It sits between the button debouncers and the home hour counter in the world-clock set mode.

## Interface
No parameters.
- CLK  in  1  system clock; all state changes on the rising edge
- RST  in  1  asynchronous reset, active-high
- HOUR  in  7  current home hour, 0..23; values 24..127 are treated as 0
- W_COUNT  in  3  city select: 0 = +2 h, 1 = −1 h, 2 = −14 h, 3..7 = −9 h (world relative to home)
- SET_EN  in  1  one-cycle pulse: enter edit mode
- UP  in  1  one-cycle pulse: edited world hour +1
- DOWN  in  1  one-cycle pulse: edited world hour −1
- COMMIT  in  1  one-cycle pulse: accept the edit
- CANCEL  in  1  one-cycle pulse: abandon the edit
- LOAD_ACK  in  1  home counter has taken HOUR_LOAD
- EDITING  out  1  high in EDIT, CONVERT and REQ
- HOUR_W_EDIT  out  7  world hour being edited, 0..23, for display
- LOAD_REQ  out  1  HOUR_LOAD is valid; held until acknowledged
- HOUR_LOAD  out  7  home hour to load, 0..23
- DAY_INC  out  1  home date = world date + 1 (conversion wrapped past 23)
- DAY_DEC  out  1  home date = world date − 1 (conversion wrapped below 0)

## Operation
- States: IDLE, EDIT, CONVERT, REQ. Reset enters IDLE.
- IDLE
  - On SET_EN, latch W_COUNT into an internal city register.
  - Load the edit register with the forward conversion of HOUR:
    - city 0: +2 mod 24
    - city 1: −1 mod 24
    - city 2: −14 mod 24
    - cities 3..7: −9 mod 24
  - Go to EDIT.
  - All other inputs are ignored in IDLE.
- EDIT
  - Input priority: CANCEL > COMMIT > UP/DOWN.
  - CANCEL returns to IDLE. No load is issued, and HOUR_LOAD and the DAY flags keep their previous values.
  - COMMIT goes to CONVERT.
  - UP increments the edit register: 23→0.
  - DOWN decrements it: 0→23.
  - UP and DOWN in the same cycle leave the register unchanged.
  - SET_EN is ignored.
  - Changes on W_COUNT after entry are ignored, because the latched city is used.
- CONVERT (exactly one cycle)
  - Compute the inverse conversion from the latched city:
    - city 0: −2
    - city 1: +1
    - city 2: +14
    - cities 3..7: +9
  - Reduce the result mod 24 into HOUR_LOAD.
  - An addition result ≥ 24 sets DAY_INC. A subtraction result < 0 sets DAY_DEC. Otherwise both are cleared.
  - DAY_INC and DAY_DEC are never both high.
  - Go to REQ.
- REQ
  - LOAD_REQ = 1.
  - HOUR_LOAD, DAY_INC and DAY_DEC are stable while LOAD_REQ is high.
  - LOAD_ACK sampled high → IDLE.
  - All user inputs, including CANCEL, are ignored.
  - There is no timeout.
- LOAD_ACK outside REQ is ignored.
- All arithmetic is done on the 7-bit value. Outputs never leave 0..23.

## Timing
- Reset values (asynchronous):
  - state = IDLE
  - EDITING = 0
  - HOUR_W_EDIT = 0
  - LOAD_REQ = 0
  - HOUR_LOAD = 0
  - DAY_INC = 0
  - DAY_DEC = 0
- SET_EN sampled at edge n → EDITING = 1 and HOUR_W_EDIT valid after edge n.
- UP/DOWN at edge n → HOUR_W_EDIT updated after edge n.
- COMMIT at edge n:
  - CONVERT after edge n.
  - LOAD_REQ = 1, with HOUR_LOAD and DAY flags valid, after edge n+1.
  - Commit-to-request latency is 2 cycles.
- LOAD_ACK sampled high at edge m while LOAD_REQ = 1 → LOAD_REQ = 0 and EDITING = 0 after edge m.
  - A same-cycle ack gives a 1-cycle request.
- HOUR_LOAD and the DAY flags hold until the next CONVERT.
- HOUR_W_EDIT holds its last value in IDLE.
- RST asserted in any state, including mid-REQ, drops LOAD_REQ and EDITING immediately without waiting for a clock. No load completes.

## Test plan
- W_COUNT=2, HOUR=5, SET_EN → HOUR_W_EDIT=15. Three UP pulses → 18. COMMIT → LOAD_REQ after 2 cycles with HOUR_LOAD=8, DAY_INC=1, DAY_DEC=0. Hold LOAD_ACK low 4 cycles: LOAD_REQ stays high and outputs are stable. LOAD_ACK → LOAD_REQ=0 and EDITING=0 next cycle.
- W_COUNT=0, HOUR=23, SET_EN → edit=1. DOWN, DOWN → 0, then 23. COMMIT → HOUR_LOAD=21, both DAY flags 0. Repeat with the edit left at 1 → HOUR_LOAD=23, DAY_DEC=1.
- W_COUNT=1, HOUR=0 → edit=23. UP → 0. COMMIT → HOUR_LOAD=1, no DAY flag. Also drive UP and DOWN in the same cycle → edit unchanged.
- W_COUNT=5, HOUR=3 → edit=18. Change W_COUNT to 0 during EDIT. COMMIT → HOUR_LOAD=3, DAY_INC=1, confirming the latched city is used.
- Priority and reset:
  - CANCEL and COMMIT in the same cycle → IDLE, no LOAD_REQ, HOUR_LOAD unchanged.
  - HOUR=30 at SET_EN with W_COUNT=0 → edit=2.
  - RST pulse mid-REQ → LOAD_REQ=0 immediately and all outputs 0.
